vocoder_mixer_n: RTL



---
 rtl/vocoder_mixer_n_pkg.sv | 26 ++
 rtl/vocoder_mixer_n_sat_shift.sv | 30 +++
 rtl/vocoder_mixer_n.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vocoder_mixer_n_pkg.sv
// Shared constants and types for the vocoder mixer and related gain stages.
package vocoder_mixer_n_pkg;

  localparam int MIX_OUT_WIDTH = 24;
  localparam int N_FILTERS     = 16;

  typedef enum logic [1:0] {
    MIX_MODE_VOCODE   = 2'd0,
    MIX_MODE_CARRIER  = 2'd1,
    MIX_MODE_ENVELOPE = 2'd2,
    MIX_MODE_MUTE     = 2'd3
  } mix_mode_e;

  typedef enum logic [1:0] {
    MIX_ST_IDLE  = 2'd0,
    MIX_ST_MAC   = 2'd1,
    MIX_ST_SCALE = 2'd2,
    MIX_ST_OUT   = 2'd3
  } mix_state_e;

  // Channel index width; a single channel still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vocoder_mixer_n_sat_shift.sv
// Combinational arithmetic right shift followed by saturation to OUT_WIDTH.
module sat_shift
  import vocoder_mixer_n_pkg::*;
#(
  parameter int ACC_WIDTH   = 67,
  parameter int SHIFT_WIDTH = 5,
  parameter int OUT_WIDTH   = MIX_OUT_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]   acc_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  output logic [OUT_WIDTH-1:0]   sat_o
);

  logic signed [ACC_WIDTH-1:0]   shifted;
  logic [ACC_WIDTH-OUT_WIDTH:0]  top_bits;

  // Shift, then clamp whenever the bits above the output sign bit disagree with it.
  always_comb begin
    shifted  = $signed(acc_i) >>> shift_i;
    top_bits = shifted[ACC_WIDTH-1:OUT_WIDTH-1];
    if (!top_bits[ACC_WIDTH-OUT_WIDTH] && (|top_bits)) begin
      sat_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (top_bits[ACC_WIDTH-OUT_WIDTH] && !(&top_bits)) begin
      sat_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      sat_o = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/vocoder_mixer_n.sv
// N-channel vocoder mixer: one time-multiplexed MAC folds all bands into a
// single saturated signed sample, with channel mask, mode select and overrun count.
module vocoder_mixer_n
  import vocoder_mixer_n_pkg::*;
#(
  parameter int N_CHANNELS  = N_FILTERS,
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = MIX_OUT_WIDTH,
  parameter int SHIFT_WIDTH = 5,
  parameter int ACC_WIDTH   = 2*IN_WIDTH + $clog2(N_CHANNELS) + 1
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                valid_in,
  input  logic [N_CHANNELS-1:0][IN_WIDTH-1:0] carrier_in,
  input  logic [N_CHANNELS-1:0][IN_WIDTH-1:0] envelope_in,
  input  logic [N_CHANNELS-1:0]               enable_mask_in,
  input  logic [1:0]                          mode_in,
  input  logic [SHIFT_WIDTH-1:0]              shift_in,
  output logic [OUT_WIDTH-1:0]                mixed_out,
  output logic                                valid_out,
  output logic                                busy_out,
  output logic [7:0]                          overrun_count_out
);

  localparam int                IDX_W    = idx_width(N_CHANNELS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_CHANNELS - 1);

  mix_state_e                          state_q;
  logic [IDX_W-1:0]                    idx_q;
  logic [ACC_WIDTH-1:0]                acc_q;
  logic [OUT_WIDTH-1:0]                result_q;
  logic [OUT_WIDTH-1:0]                mixed_q;
  logic                                valid_q;
  logic                                busy_q;
  logic [7:0]                          ovr_q;
  logic [N_CHANNELS-1:0][IN_WIDTH-1:0] carrier_q;
  logic [N_CHANNELS-1:0][IN_WIDTH-1:0] envelope_q;
  logic [N_CHANNELS-1:0]               mask_q;
  mix_mode_e                           mode_q;
  logic [SHIFT_WIDTH-1:0]              shift_q;

  logic signed [IN_WIDTH-1:0]          car_s;
  logic signed [IN_WIDTH-1:0]          env_s;
  logic signed [2*IN_WIDTH-1:0]        prod_s;
  logic signed [ACC_WIDTH-1:0]         term_d;
  logic [OUT_WIDTH-1:0]                sat_d;

  // Per-channel term for the current index, sign-extended to accumulator width.
  always_comb begin
    car_s  = carrier_q[idx_q];
    env_s  = envelope_q[idx_q];
    prod_s = car_s * env_s;
    term_d = '0;
    if (mask_q[idx_q]) begin
      unique case (mode_q)
        MIX_MODE_VOCODE:   term_d = ACC_WIDTH'(prod_s);
        MIX_MODE_CARRIER:  term_d = ACC_WIDTH'(car_s);
        MIX_MODE_ENVELOPE: term_d = ACC_WIDTH'(env_s);
        default:           term_d = '0;
      endcase
    end
  end

  sat_shift #(
    .ACC_WIDTH   (ACC_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH)
  ) u_sat_shift (
    .acc_i   (acc_q),
    .shift_i (shift_q),
    .sat_o   (sat_d)
  );

  // Sequencer: accept/snapshot, MAC over channels, scale, publish; plus overrun count.
  // The scaled result is staged in result_q and published from OUT, so mixed_out and
  // valid_out change together N_CHANNELS+2 edges after the accepting edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= MIX_ST_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      mixed_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= '0;
      carrier_q  <= '0;
      envelope_q <= '0;
      mask_q     <= '0;
      mode_q     <= MIX_MODE_MUTE;
      shift_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (valid_in && busy_q && (ovr_q != '1)) begin
        ovr_q <= ovr_q + 8'd1;
      end
      unique case (state_q)
        MIX_ST_IDLE, MIX_ST_OUT: begin
          if (state_q == MIX_ST_OUT) begin
            mixed_q <= result_q;
            valid_q <= 1'b1;
          end
          if (valid_in) begin
            carrier_q  <= carrier_in;
            envelope_q <= envelope_in;
            mask_q     <= enable_mask_in;
            mode_q     <= mix_mode_e'(mode_in);
            shift_q    <= shift_in;
            acc_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= MIX_ST_MAC;
          end else begin
            state_q <= MIX_ST_IDLE;
          end
        end
        MIX_ST_MAC: begin
          acc_q <= acc_q + term_d;
          if (idx_q == LAST_IDX) begin
            state_q <= MIX_ST_SCALE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        MIX_ST_SCALE: begin
          result_q <= sat_d;
          busy_q   <= 1'b0;
          state_q  <= MIX_ST_OUT;
        end
        default: state_q <= MIX_ST_IDLE;
      endcase
    end
  end

  assign mixed_out         = mixed_q;
  assign valid_out         = valid_q;
  assign busy_out          = busy_q;
  assign overrun_count_out = ovr_q;

endmodule
